timer_seq_ctrl: RTL

APB master sequencer that configures and runs the timer IP without CPU involvement.
- On start: loads TDR, loads the counter, enables counting, then polls TSR for overflow/underflow.
- Clears each flag and counts events; stops the timer after a programmed number of events.
- Sits between a host control interface and the timer's APB slave port, in place of the cpu bus model.

---
 rtl/timer_seq_ctrl.sv | 246 ++++++++++++++++++++++++
 1 files changed

// File: rtl/timer_seq_ctrl.sv
// -----------------------------------------------------------------------------
// timer_seq_ctrl
// APB master sequencer that programs and runs the timer IP with no CPU help.
// On an accepted start it writes TDR, pulses the TCR load bit, enables
// counting, then polls TSR for the selected flag. Each event is cleared
// (write-1-to-clear) and counted. After cfg_reps events, or on a stop request,
// the timer is disabled and done pulses.
//
// Ports
//   pclk, presetn           : clock, asynchronous active-low reset
//   start, stop             : 1-cycle control pulses from the host
//   cfg_tdr/up_down/cks/reps: sequence configuration, sampled on accepted start
//   busy, done, err, evt_cnt: host status
//   psel..pwdata, prdata,
//   pready                  : APB master port towards the timer slave
//
// Optional build macro: TMR_SEQ_TIMEOUT_EN
//   When defined, an access phase lasting TIMEOUT cycles without pready is
//   abandoned; err is set and the sequence goes straight to FIN.
// -----------------------------------------------------------------------------
module timer_seq_ctrl #(
  parameter int CNT_W    = 8,
  parameter int POLL_GAP = 4,
  parameter int TIMEOUT  = 16
) (
  input  logic             pclk,
  input  logic             presetn,
  input  logic             start,
  input  logic             stop,
  input  logic [7:0]       cfg_tdr,
  input  logic             cfg_up_down,
  input  logic [1:0]       cfg_cks,
  input  logic [CNT_W-1:0] cfg_reps,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CNT_W-1:0] evt_cnt,
  output logic             psel,
  output logic             penable,
  output logic             pwrite,
  output logic [7:0]       paddr,
  output logic [7:0]       pwdata,
  input  logic [7:0]       prdata,
  input  logic             pready
);

  localparam logic [7:0] ADDR_TDR = 8'h00;
  localparam logic [7:0] ADDR_TCR = 8'h01;
  localparam logic [7:0] ADDR_TSR = 8'h02;
  localparam int GAP_W = (POLL_GAP > 1) ? $clog2(POLL_GAP) : 1;

  typedef enum logic [3:0] {
    S_IDLE, S_W_TDR, S_W_LOAD, S_W_RUN, S_GAP, S_R_TSR, S_W_CLR, S_W_STOP, S_FIN
  } state_t;

  state_t           state_q;
  logic [7:0]       tdr_q;
  logic             ud_q;
  logic [1:0]       cks_q;
  logic [CNT_W-1:0] target_q;
  logic             stop_pend_q;
  logic [GAP_W-1:0] gap_q;
  logic             busy_q, done_q, err_q;
  logic [CNT_W-1:0] evt_q;
  logic             psel_q, penable_q, pwrite_q;
  logic [7:0]       paddr_q, pwdata_q;

`ifdef TMR_SEQ_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  logic [TO_W-1:0]  to_q;
`endif

  // Combinational decode of the current bus state's transfer and its successor
  logic [7:0]       tcr_base_d, tsr_mask_d, bus_addr_d, bus_wdata_d;
  logic             bus_write_d;
  logic [CNT_W:0]   evt_sum_d;
  logic [CNT_W-1:0] evt_sat_d;
  state_t           poll_st_d, xfer_base_d, xfer_next_d;

  // Transfer contents, event arithmetic and post-transfer state selection
  always_comb begin
    tcr_base_d  = {1'b0, 1'b0, ud_q, 1'b0, 2'b00, cks_q};
    tsr_mask_d  = ud_q ? 8'h02 : 8'h01;
    evt_sum_d   = {1'b0, evt_q} + {{CNT_W{1'b0}}, 1'b1};
    // Counter saturates at all-ones rather than wrapping
    evt_sat_d   = (&evt_q) ? evt_q : evt_sum_d[CNT_W-1:0];
    // A zero poll gap skips the GAP state entirely
    poll_st_d   = (POLL_GAP == 0) ? S_R_TSR : S_GAP;
    bus_addr_d  = ADDR_TDR;
    bus_wdata_d = 8'h00;
    bus_write_d = 1'b1;
    xfer_base_d = S_FIN;
    case (state_q)
      S_W_TDR: begin
        bus_wdata_d = tdr_q;
        xfer_base_d = S_W_LOAD;
      end
      S_W_LOAD: begin
        bus_addr_d  = ADDR_TCR;
        bus_wdata_d = tcr_base_d | 8'h80;
        xfer_base_d = S_W_RUN;
      end
      S_W_RUN: begin
        bus_addr_d  = ADDR_TCR;
        bus_wdata_d = tcr_base_d | 8'h10;
        xfer_base_d = poll_st_d;
      end
      S_R_TSR: begin
        bus_addr_d  = ADDR_TSR;
        bus_write_d = 1'b0;
        // Only the flag matching the count direction counts as an event
        xfer_base_d = ((prdata & tsr_mask_d) != 8'h00) ? S_W_CLR : poll_st_d;
      end
      S_W_CLR: begin
        bus_addr_d  = ADDR_TSR;
        bus_wdata_d = tsr_mask_d;
        xfer_base_d = (evt_sum_d >= {1'b0, target_q}) ? S_W_STOP : poll_st_d;
      end
      S_W_STOP: begin
        bus_addr_d  = ADDR_TCR;
        bus_wdata_d = tcr_base_d;
        xfer_base_d = S_FIN;
      end
      default: begin
        xfer_base_d = S_FIN;
      end
    endcase
    // A pending stop redirects to the disable write once the transfer ends
    xfer_next_d = (stop_pend_q && (state_q != S_W_STOP)) ? S_W_STOP : xfer_base_d;
  end

  // Sequencer FSM with APB phase tracking and registered outputs
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q     <= S_IDLE;
      tdr_q       <= 8'h00;
      ud_q        <= 1'b0;
      cks_q       <= 2'b00;
      target_q    <= {CNT_W{1'b0}};
      stop_pend_q <= 1'b0;
      gap_q       <= {GAP_W{1'b0}};
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      evt_q       <= {CNT_W{1'b0}};
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= 8'h00;
      pwdata_q    <= 8'h00;
`ifdef TMR_SEQ_TIMEOUT_EN
      to_q        <= {TO_W{1'b0}};
`endif
    end else begin
      done_q <= 1'b0;
      if (busy_q && stop) begin
        stop_pend_q <= 1'b1;
      end
      case (state_q)
        S_IDLE: begin
          // stop in the same cycle is irrelevant: busy_q is still low here
          if (start) begin
            tdr_q       <= cfg_tdr;
            ud_q        <= cfg_up_down;
            cks_q       <= cfg_cks;
            target_q    <= (cfg_reps == {CNT_W{1'b0}}) ? {{(CNT_W-1){1'b0}}, 1'b1} : cfg_reps;
            evt_q       <= {CNT_W{1'b0}};
            err_q       <= 1'b0;
            stop_pend_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= S_W_TDR;
          end
        end
        S_GAP: begin
          if (stop_pend_q) begin
            state_q <= S_W_STOP;
          end else if (gap_q == GAP_W'(POLL_GAP - 1)) begin
            state_q <= S_R_TSR;
          end else begin
            gap_q <= gap_q + GAP_W'(1);
          end
        end
        S_FIN: begin
          busy_q      <= 1'b0;
          done_q      <= 1'b1;
          stop_pend_q <= 1'b0;
          state_q     <= S_IDLE;
        end
        S_W_TDR, S_W_LOAD, S_W_RUN, S_R_TSR, S_W_CLR, S_W_STOP: begin
          if (!psel_q) begin
            // Bus idle: either divert to the stop write or open a setup phase
            if (stop_pend_q && (state_q != S_W_STOP)) begin
              state_q <= S_W_STOP;
            end else begin
              psel_q   <= 1'b1;
              pwrite_q <= bus_write_d;
              paddr_q  <= bus_addr_d;
              pwdata_q <= bus_wdata_d;
            end
          end else if (!penable_q) begin
            penable_q <= 1'b1;
`ifdef TMR_SEQ_TIMEOUT_EN
            to_q      <= {TO_W{1'b0}};
`endif
          end else if (pready) begin
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            gap_q     <= {GAP_W{1'b0}};
            state_q   <= xfer_next_d;
            if (state_q == S_W_CLR) begin
              evt_q <= evt_sat_d;
            end
          end
`ifdef TMR_SEQ_TIMEOUT_EN
          else if (to_q == TO_W'(TIMEOUT - 1)) begin
            // Slave never answered: abandon the transfer, no disable write
            psel_q    <= 1'b0;
            penable_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= S_FIN;
          end else begin
            to_q <= to_q + TO_W'(1);
          end
`endif
        end
        default: begin
          // Unreachable encoding: release the bus and terminate cleanly
          psel_q    <= 1'b0;
          penable_q <= 1'b0;
          state_q   <= S_FIN;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign evt_cnt = evt_q;
  assign psel    = psel_q;
  assign penable = penable_q;
  assign pwrite  = pwrite_q;
  assign paddr   = paddr_q;
  assign pwdata  = pwdata_q;

endmodule
